led_status_tx: RTL and testbench

- Transmit-side counterpart to the LED command parser.
- On a report request, formats one LED status line as ASCII and streams it byte by byte into the UART transmitter through its i_Start / i_Data / o_Busy_TX handshake.
- Sits between LED control logic and the UART module. It shares the UART TX port with the echo path, so arbitration is external.
- Message format: colour char ('r'/'g'/'b'), LED digit ('1'..'4'), '=', two uppercase hex digits of the level, '\n'.

---
 rtl/led_uart_pkg.sv | 42 ++++
 rtl/led_status_tx_if.sv | 23 ++
 rtl/led_status_tx.sv | 143 ++++++++++++++
 tb/tb_led_status_tx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_uart_pkg.sv
// Shared constants, ASCII helpers and FSM encoding for the LED UART status path.
// Macro LED_STATUS_TX_CRLF_EN selects a CR+LF line ending instead of LF only.
package led_uart_pkg;

   localparam logic [1:0] RED   = 2'd0;
   localparam logic [1:0] GREEN = 2'd1;
   localparam logic [1:0] BLUE  = 2'd2;

   localparam logic [7:0] CHAR_R  = 8'h72;
   localparam logic [7:0] CHAR_G  = 8'h67;
   localparam logic [7:0] CHAR_B  = 8'h62;
   localparam logic [7:0] CHAR_Q  = 8'h3F;
   localparam logic [7:0] CHAR_EQ = 8'h3D;
   localparam logic [7:0] CHAR_LF = 8'h0A;
   localparam logic [7:0] CHAR_CR = 8'h0D;
   localparam logic [7:0] CHAR_0  = 8'h30;

`ifdef LED_STATUS_TX_CRLF_EN
   localparam int MSG_LEN = 7;
`else
   localparam int MSG_LEN = 6;
`endif
   localparam int IDX_W = 3;

   // Uppercase hex: 'A' - 10 = 8'h37
   function automatic logic [7:0] hex_to_ascii(input logic [3:0] i_Nibble);
      if (i_Nibble < 4'd10)
         return CHAR_0 + {4'h0, i_Nibble};
      else
         return 8'h37 + {4'h0, i_Nibble};
   endfunction

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT_HI,
      S_WAIT_LO,
      S_NEXT
   } state_t;

endpackage

// File: rtl/led_status_tx_if.sv
// Request, UART transmit handshake and status signals of the LED status transmitter.
interface led_status_tx_if;
   logic       i_Report;
   logic [1:0] i_Colour;
   logic [1:0] i_Number;
   logic [7:0] i_Level;
   logic       o_Start;
   logic [7:0] o_Data;
   logic       i_Busy_TX;
   logic       o_Busy;
   logic       o_Done;
   logic       o_Overrun;

   modport master (
      output i_Report, i_Colour, i_Number, i_Level, i_Busy_TX,
      input  o_Start, o_Data, o_Busy, o_Done, o_Overrun
   );

   modport slave (
      input  i_Report, i_Colour, i_Number, i_Level, i_Busy_TX,
      output o_Start, o_Data, o_Busy, o_Done, o_Overrun
   );
endinterface

// File: rtl/led_status_tx.sv
// Formats one LED status line ("<c><d>=<HH>\n") and streams it into the UART TX handshake.
// Macro LED_STATUS_TX_CRLF_EN adds a CR before the LF.
module led_status_tx
   import led_uart_pkg::*;
#(
   parameter int BUSY_WAIT_CYCLES = 4,
   parameter int WAIT_W           = 3
) (
   input logic             Clock,
   input logic             Reset,
   led_status_tx_if.slave  bus
);

   state_t             r_State, w_State_nxt;
   logic [IDX_W-1:0]   r_Index, w_Index_nxt;
   logic [WAIT_W-1:0]  r_Wait,  w_Wait_nxt;
   logic [1:0]         r_Colour, r_Number;
   logic [7:0]         r_Level;
   logic               w_Capture;
   logic               r_Start, w_Start_nxt;
   logic [7:0]         r_Data,  w_Data_nxt;
   logic               r_Busy,  w_Busy_nxt;
   logic               r_Done,  w_Done_nxt;
   logic               r_Overrun, w_Overrun_nxt;
   logic [7:0]         w_Byte;

   always_comb begin
      w_Byte = CHAR_LF;
      case (r_Index)
         3'd0: begin
            case (r_Colour)
               RED:     w_Byte = CHAR_R;
               GREEN:   w_Byte = CHAR_G;
               BLUE:    w_Byte = CHAR_B;
               default: w_Byte = CHAR_Q;
            endcase
         end
         3'd1: w_Byte = 8'h31 + {6'b0, r_Number};
         3'd2: w_Byte = CHAR_EQ;
         3'd3: w_Byte = hex_to_ascii(r_Level[7:4]);
         3'd4: w_Byte = hex_to_ascii(r_Level[3:0]);
`ifdef LED_STATUS_TX_CRLF_EN
         3'd5: w_Byte = CHAR_CR;
`endif
         default: w_Byte = CHAR_LF;
      endcase
   end

   always_comb begin
      w_State_nxt   = r_State;
      w_Index_nxt   = r_Index;
      w_Wait_nxt    = r_Wait;
      w_Capture     = 1'b0;
      w_Start_nxt   = 1'b0;
      w_Data_nxt    = r_Data;
      w_Busy_nxt    = r_Busy;
      w_Done_nxt    = 1'b0;
      w_Overrun_nxt = bus.i_Report & r_Busy;
      case (r_State)
         S_IDLE: begin
            // The cycle showing o_Done is deliberately not an acceptance cycle
            if (bus.i_Report && !r_Done) begin
               w_Capture   = 1'b1;
               w_Busy_nxt  = 1'b1;
               w_Index_nxt = '0;
               w_State_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            if (!bus.i_Busy_TX) begin
               w_Data_nxt  = w_Byte;
               w_Start_nxt = 1'b1;
               w_State_nxt = S_START;
            end
         end
         S_START: begin
            w_Wait_nxt  = '0;
            w_State_nxt = S_WAIT_HI;
         end
         S_WAIT_HI: begin
            if (bus.i_Busy_TX)
               w_State_nxt = S_WAIT_LO;
            else if (r_Wait == WAIT_W'(BUSY_WAIT_CYCLES))
               w_State_nxt = S_NEXT;
            else
               w_Wait_nxt = r_Wait + WAIT_W'(1);
         end
         S_WAIT_LO: begin
            if (!bus.i_Busy_TX)
               w_State_nxt = S_NEXT;
         end
         S_NEXT: begin
            if (r_Index == IDX_W'(MSG_LEN - 1)) begin
               w_Done_nxt  = 1'b1;
               w_Busy_nxt  = 1'b0;
               w_Index_nxt = '0;
               w_State_nxt = S_IDLE;
            end else begin
               w_Index_nxt = r_Index + IDX_W'(1);
               w_State_nxt = S_LOAD;
            end
         end
         default: w_State_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_State   <= S_IDLE;
         r_Index   <= '0;
         r_Wait    <= '0;
         r_Colour  <= '0;
         r_Number  <= '0;
         r_Level   <= '0;
         r_Start   <= 1'b0;
         r_Data    <= 8'h00;
         r_Busy    <= 1'b0;
         r_Done    <= 1'b0;
         r_Overrun <= 1'b0;
      end else begin
         r_State   <= w_State_nxt;
         r_Index   <= w_Index_nxt;
         r_Wait    <= w_Wait_nxt;
         r_Start   <= w_Start_nxt;
         r_Data    <= w_Data_nxt;
         r_Busy    <= w_Busy_nxt;
         r_Done    <= w_Done_nxt;
         r_Overrun <= w_Overrun_nxt;
         if (w_Capture) begin
            r_Colour <= bus.i_Colour;
            r_Number <= bus.i_Number;
            r_Level  <= bus.i_Level;
         end
      end
   end

   assign bus.o_Start   = r_Start;
   assign bus.o_Data    = r_Data;
   assign bus.o_Busy    = r_Busy;
   assign bus.o_Done    = r_Done;
   assign bus.o_Overrun = r_Overrun;

endmodule

// File: tb/tb_led_status_tx.sv
// Scoreboard bench for led_status_tx: requests push expected bytes, a monitor pops them on o_Start.
module tb_led_status_tx;

   localparam int BWC = 4;
`ifdef LED_STATUS_TX_CRLF_EN
   localparam int EXP_LEN = 7;
`else
   localparam int EXP_LEN = 6;
`endif

   logic Clock = 1'b0;
   logic Reset = 1'b1;

   led_status_tx_if bus();

   led_status_tx #(.BUSY_WAIT_CYCLES(BWC), .WAIT_W(3)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clock = ~Clock;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   int start_cnt = 0;
   int done_cnt  = 0;
   int ovr_cnt   = 0;

   // UART model: mode 0 = busy ~10 cycles per byte, mode 1 = never busy
   int   uart_mode = 0;
   int   uart_left = 0;
   logic uart_busy = 1'b0;
   logic foreign_busy = 1'b0;
   assign bus.i_Busy_TX = uart_busy | foreign_busy;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   function automatic logic [7:0] hexch(input logic [3:0] n);
      if (n < 4'd10) return 8'h30 + {4'h0, n};
      return 8'h41 + ({4'h0, n} - 8'd10);
   endfunction

   function automatic void push_msg(input logic [1:0] c, input logic [1:0] n, input logic [7:0] l);
      logic [7:0] col[4];
      col = '{8'h72, 8'h67, 8'h62, 8'h3F};
      exp_q.push_back(col[c]);
      exp_q.push_back(8'h31 + {6'b0, n});
      exp_q.push_back(8'h3D);
      exp_q.push_back(hexch(l[7:4]));
      exp_q.push_back(hexch(l[3:0]));
`ifdef LED_STATUS_TX_CRLF_EN
      exp_q.push_back(8'h0D);
`endif
      exp_q.push_back(8'h0A);
   endfunction

   always @(negedge Clock) begin
      if (Reset) begin
         uart_left = 0;
         uart_busy = 1'b0;
      end else begin
         if (uart_left > 0) uart_left--;
         if (bus.o_Start && uart_mode == 0) uart_left = 10;
         uart_busy = (uart_left > 0);
      end
   end

   always @(negedge Clock) begin
      if (!Reset) begin
         if (bus.o_Start) begin
            start_cnt++;
            check("start_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("byte", int'(bus.o_Data), int'(exp_q.pop_front()));
         end
         if (bus.o_Done)    done_cnt++;
         if (bus.o_Overrun) ovr_cnt++;
      end
   end

   task automatic check_outputs_zero(input string tag);
      check({tag, "_start"},   int'(bus.o_Start), 0);
      check({tag, "_data"},    int'(bus.o_Data), 0);
      check({tag, "_busy"},    int'(bus.o_Busy), 0);
      check({tag, "_done"},    int'(bus.o_Done), 0);
      check({tag, "_overrun"}, int'(bus.o_Overrun), 0);
   endtask

   task automatic request(input logic [1:0] c, input logic [1:0] n, input logic [7:0] l);
      int t = 0;
      @(negedge Clock);
      while ((bus.o_Busy || bus.o_Done) && t < 2000) begin
         @(negedge Clock);
         t++;
      end
      check("idle_before_request", int'(bus.o_Busy), 0);
      bus.i_Colour = c;
      bus.i_Number = n;
      bus.i_Level  = l;
      bus.i_Report = 1'b1;
      push_msg(c, n, l);
      @(negedge Clock);
      bus.i_Report = 1'b0;
      bus.i_Colour = 2'($urandom_range(0, 3));
      bus.i_Number = 2'($urandom_range(0, 3));
      bus.i_Level  = 8'($urandom_range(0, 255));
      check("busy_after_accept", int'(bus.o_Busy), 1);
   endtask

   task automatic wait_done(input string name, input int budget, input int s0, input int d0);
      int t = 0;
      while (!bus.o_Done && t < budget) begin
         @(negedge Clock);
         t++;
      end
      check({name, "_done_in_time"}, int'(bus.o_Done), 1);
      @(negedge Clock);
      #1;
      check({name, "_busy_low"},   int'(bus.o_Busy), 0);
      check({name, "_starts"},     start_cnt - s0, EXP_LEN);
      check({name, "_done_count"}, done_cnt - d0, 1);
      check({name, "_queue_empty"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, d0, o0, t;
      bus.i_Report = 1'b0;
      bus.i_Colour = 2'd0;
      bus.i_Number = 2'd0;
      bus.i_Level  = 8'd0;
      Reset = 1'b1;
      repeat (3) @(negedge Clock);
      check_outputs_zero("reset");
      Reset = 1'b0;

      // Basic message plus first-start latency
      uart_mode = 0;
      s0 = start_cnt; d0 = done_cnt;
      request(2'd0, 2'd0, 8'h11);
      @(negedge Clock);
      check("first_start_latency", int'(bus.o_Start), 1);
      wait_done("msg_r1", 400, s0, d0);

      s0 = start_cnt; d0 = done_cnt;
      request(2'd3, 2'd3, 8'hAF);
      wait_done("msg_q4", 400, s0, d0);

      // Overrun during a message
      s0 = start_cnt; d0 = done_cnt; o0 = ovr_cnt;
      request(2'd1, 2'd2, 8'h5C);
      repeat (2) @(negedge Clock);
      bus.i_Report = 1'b1;
      @(negedge Clock);
      bus.i_Report = 1'b0;
      wait_done("msg_overrun", 400, s0, d0);
      check("overrun_pulses", ovr_cnt - o0, 1);

      // Foreign transmission holding busy
      foreign_busy = 1'b1;
      s0 = start_cnt; d0 = done_cnt;
      request(2'd2, 2'd1, 8'h3E);
      repeat (50) @(negedge Clock);
      check("no_start_while_foreign_busy", start_cnt - s0, 0);
      foreign_busy = 1'b0;
      wait_done("msg_foreign", 400, s0, d0);

      // UART never raises busy: timeout path
      uart_mode = 1;
      s0 = start_cnt; d0 = done_cnt;
      request(2'd1, 2'd0, 8'h9B);
      wait_done("msg_nobusy", EXP_LEN * (BWC + 4) + 2, s0, d0);

      // Randomized messages
      for (int i = 0; i < 12; i++) begin
         uart_mode = int'($urandom_range(0, 1));
         s0 = start_cnt; d0 = done_cnt;
         request(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
         wait_done("msg_rand", 400, s0, d0);
      end

      // Reset in the middle of byte 3
      uart_mode = 0;
      s0 = start_cnt;
      request(2'd1, 2'd0, 8'h77);
      t = 0;
      while (start_cnt - s0 < 4 && t < 400) begin
         @(negedge Clock);
         t++;
      end
      check("reached_byte3", int'(start_cnt - s0 >= 4), 1);
      Reset = 1'b1;
      #1;
      check_outputs_zero("midreset");
      exp_q.delete();
      @(negedge Clock);
      check_outputs_zero("midreset_hold");
      Reset = 1'b0;
      s0 = start_cnt; d0 = done_cnt;
      request(2'd0, 2'd0, 8'h00);
      wait_done("msg_after_reset", 400, s0, d0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
